// File: rtl/serial_acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_acc_ctrl_pkg
// Description : Shared definitions for the bit-serial accumulator controller.
//               Holds the FSM state encoding, the default operand and
//               accumulator widths, and the bit-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_acc_ctrl_pkg;

  localparam int C_DATA_W = 8;
  localparam int C_ACC_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter must be able to hold ACC_W itself, not just ACC_W-1.
  function automatic int cnt_w(input int acc_w);
    return $clog2(acc_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : serial_shift_reg
// Description : LSB-first shift register. The LSB is presented on q[0] and a
//               new bit enters at the MSB on every shift. Used for both the
//               accumulator and the operand of the bit-serial adder.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n     - clock, async active-low reset
//               clr            - synchronous clear (highest priority)
//               load, load_val - parallel load
//               shift,shift_in - shift right, shift_in enters at the MSB
//               q              - register contents
// ============================================================================
module serial_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             shift_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_val;
    end else if (shift) begin
      r_q <= {shift_in, r_q[WIDTH-1:1]};
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/serial_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_acc_ctrl
// Description : Bit-serial accumulator controller. Drives one external 1-bit
//               full-adder cell LSB-first to add each accepted operand into
//               an ACC_W-bit running sum; the sum is presented when the row's
//               last operand (in_last) has been added.
//               Optional macro SERIAL_ACC_SAT_EN: saturate out_data to all
//               ones when the row overflowed (internal sum still wraps).
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n                  - clock, async active-low reset
//               in_valid/in_ready/in_data/in_last - operand stream
//               out_valid/out_ready/out_data/out_ovf - result stream
//               busy                        - controller not idle
//               fa_a/fa_b/fa_cin            - to the external adder cell
//               fa_s/fa_cout                - combinational adder return
// ============================================================================
module serial_acc_ctrl
  import serial_acc_ctrl_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int ACC_W  = C_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              busy,
  output logic              fa_a,
  output logic              fa_b,
  output logic              fa_cin,
  input  logic              fa_s,
  input  logic              fa_cout
);

  localparam int CNT_W = cnt_w(ACC_W);

  state_t             r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_carry;
  logic               r_last_q;
  logic               r_ovf;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_data;
  logic               r_out_ovf;
  logic               r_busy;

  logic [ACC_W-1:0]   w_acc;
  logic [ACC_W-1:0]   w_opnd;
  logic [ACC_W-1:0]   w_acc_next;
  logic [ACC_W-1:0]   w_result;
  logic               w_accept;
  logic               w_in_add;
  logic               w_last_bit;
  logic               w_out_fire;
  logic               w_ovf_next;

  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_in_add   = (r_state == ST_ADD);
  assign w_last_bit = w_in_add && (r_bit_cnt == CNT_W'(ACC_W - 1));
  // out_valid is only ever high in DONE, so this is the DONE handshake.
  assign w_out_fire = r_out_valid && out_ready;
  assign w_ovf_next = r_ovf | fa_cout;
  // Value the accumulator takes at the end of this ADD cycle; on the final
  // bit this is the completed sum, captured straight into out_data.
  assign w_acc_next = {fa_s, w_acc[ACC_W-1:1]};

`ifdef SERIAL_ACC_SAT_EN
  assign w_result = w_ovf_next ? {ACC_W{1'b1}} : w_acc_next;
`else
  assign w_result = w_acc_next;
`endif

  // Accumulator: rotates the sum bit in at the MSB; cleared once the row's
  // result has been handed downstream.
  serial_shift_reg #(.WIDTH(ACC_W)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_out_fire),
    .load     (1'b0),
    .load_val ({ACC_W{1'b0}}),
    .shift    (w_in_add),
    .shift_in (fa_s),
    .q        (w_acc)
  );

  // Operand: loaded zero-extended at acceptance, drained LSB-first.
  serial_shift_reg #(.WIDTH(ACC_W)) u_opnd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     (w_accept),
    .load_val (ACC_W'(in_data)),
    .shift    (w_in_add),
    .shift_in (1'b0),
    .q        (w_opnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_carry     <= 1'b0;
      r_last_q    <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_last_q  <= in_last;
            r_carry   <= 1'b0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_carry   <= fa_cout;
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          if (w_last_bit) begin
            r_ovf <= w_ovf_next;
            if (r_last_q) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_result;
              r_out_ovf   <= w_ovf_next;
              r_state     <= ST_DONE;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign busy      = r_busy;

  // Adder inputs are only live during ADD so the cell sees zeros otherwise.
  assign fa_a   = w_in_add & w_acc[0];
  assign fa_b   = w_in_add & w_opnd[0];
  assign fa_cin = w_in_add & r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_acc_ctrl
// Description : Self-checking bench for serial_acc_ctrl. Hosts the 1-bit
//               full-adder cell and compares the DUT against an arithmetic
//               reference (true running sum, per-bit carries from masked adds).
//               Honours SERIAL_ACC_SAT_EN for the expected result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_acc_ctrl;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;
  logic              busy;
  logic              fa_a, fa_b, fa_cin;
  logic              fa_s, fa_cout;

  int total = 0;
  int bad   = 0;
  longint unsigned model_sum = 0;

  always #5 clk = ~clk;

  // External full-adder cell.
  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_acc_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_s      (fa_s),
    .fa_cout   (fa_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one operand from IDLE, then watch every ADD cycle against the
  // reference bit-serial adder. Returns at the first cycle after ADD.
  task automatic send_op(input logic [DATA_W-1:0] d, input bit last);
    int unsigned dd;
    int unsigned acc_old;
    int unsigned m;
    int waited;
    dd      = d;
    acc_old = int'(model_sum % 65536);
    waited  = 0;
    while (in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", in_ready, 1);
    check("idle_fa", {fa_a, fa_b, fa_cin}, 0);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    // Post-acceptance changes must be ignored.
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    in_last  = 1'($urandom);
    for (int i = 0; i < ACC_W; i++) begin
      m = (32'd1 << i) - 32'd1;
      check("add_fa_a",   fa_a,   (acc_old >> i) & 1);
      check("add_fa_b",   fa_b,   (dd >> i) & 1);
      check("add_fa_cin", fa_cin, (((acc_old & m) + (dd & m)) >> i) & 1);
      check("add_ready",  in_ready, 0);
      check("add_busy",   busy, 1);
      check("add_ovalid", out_valid, 0);
      out_ready = 1'($urandom);  // no effect while out_valid is low
      @(negedge clk);
    end
    out_ready = 1'b0;
    model_sum += dd;
    if (last) begin
      check("latency_ovalid", out_valid, 1);
    end else begin
      check("next_ready", in_ready, 1);
      check("next_ovalid", out_valid, 0);
    end
  endtask

  // Check the held result for hold cycles (optionally with in_valid high),
  // then complete the handshake.
  task automatic finish_row(input int hold, input bit valid_during_hold);
    logic [ACC_W-1:0] exp_data;
    bit exp_ovf;
    exp_ovf  = (model_sum >= 64'd65536);
    exp_data = ACC_W'(model_sum % 65536);
`ifdef SERIAL_ACC_SAT_EN
    if (exp_ovf) exp_data = '1;
`endif
    in_valid = valid_during_hold;
    in_data  = DATA_W'($urandom);
    for (int k = 0; k <= hold; k++) begin
      check("done_valid", out_valid, 1);
      check("done_data",  out_data, exp_data);
      check("done_ovf",   out_ovf, exp_ovf);
      check("done_ready", in_ready, 0);
      check("done_fa",    {fa_a, fa_b, fa_cin}, 0);
      if (k < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_ovalid", out_valid, 0);
    check("post_ready",  in_ready, 1);
    check("post_busy",   busy, 0);
    model_sum = 0;
  endtask

  initial begin
    int n_ready;
    int len;
    logic [DATA_W-1:0] sd;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ovalid", out_valid, 0);
    check("rst_odata",  out_data, 0);
    check("rst_oovf",   out_ovf, 0);
    check("rst_busy",   busy, 0);
    check("rst_fa",     {fa_a, fa_b, fa_cin}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1);

    // Row {3,5,7}
    send_op(8'd3, 0); send_op(8'd5, 0); send_op(8'd7, 1);
    finish_row(0, 0);

    // Single operand, result stalled 10 cycles with in_valid pushing.
    send_op(8'hA5, 1);
    finish_row(10, 1);
    send_op(8'h11, 1);
    finish_row(1, 0);

    // in_valid held continuously: one accept per ACC_W+1 cycles.
    sd = 8'h2B;
    in_valid = 1'b1; in_data = sd; in_last = 1'b0;
    n_ready = 0;
    for (int k = 0; k < 3 * (ACC_W + 1); k++) begin
      check("stream_ready", in_ready, (k % (ACC_W + 1)) == 0);
      if (in_ready === 1'b1) n_ready++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stream_accepts", n_ready, 3);
    model_sum += 3 * sd;
    send_op(8'h40, 1);
    finish_row(0, 0);

    // Abort with reset at ADD cycle 5 of the second operand.
    send_op(8'h33, 1);
    finish_row(0, 0);  // leaves a nonzero out_data behind
    send_op(8'd9, 0);
    in_valid = 1'b1; in_data = 8'd4; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ovalid", out_valid, 0);
    check("arst_odata",  out_data, 0);
    check("arst_oovf",   out_ovf, 0);
    check("arst_busy",   busy, 0);
    check("arst_ready",  in_ready, 1);
    check("arst_fa",     {fa_a, fa_b, fa_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_sum = 0;
    @(negedge clk);
    send_op(8'd2, 0); send_op(8'd2, 1);
    finish_row(0, 0);

    // 257 x 0xFF -> 0xFFFF, no overflow.
    for (int k = 0; k < 256; k++) send_op(8'hFF, 0);
    send_op(8'hFF, 1);
    finish_row(0, 0);
    // Same plus one more 0x01 -> wrap with overflow.
    for (int k = 0; k < 257; k++) send_op(8'hFF, 0);
    send_op(8'h01, 1);
    finish_row(2, 0);

    // Randomized rows.
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) send_op(DATA_W'($urandom), (k == len - 1));
      finish_row($urandom_range(0, 3), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
